trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
Consumer end of the exception priority path. Takes the arbitrated pending flag and cause, drains the pipeline, and writes mcause/mepc/mtval. It then redirects fetch to the mtvec target and pulses the "handled" acknowledge that clears the sticky pending vector. It also sequences mret (flush, mstatus pop, redirect to mepc). Sits between the exception priority unit, the CSR file and the fetch stage.

Parameters:
VECTORED_EN, 1, enable mtvec vectored mode for interrupts (0: always direct)
MTVAL_EN, 1, write i_trap_val to mtval (0: mtval written as 0)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_trap_pending  in  1  arbitrated exception/interrupt pending
i_trap_cause  in  32  mcause value; bit31 = interrupt
i_trap_pc  in  32  pc of trapping instruction
i_trap_val  in  32  faulting address/instruction
i_mret  in  1  mret reached commit
i_mtvec  in  32  current mtvec CSR
i_mepc  in  32  current mepc CSR
i_pipe_empty  in  1  pipeline drained, no side effects in flight
o_flush  out  1  kill/drain pipeline
o_csr_we  out  1  write o_mcause/o_mepc/o_mtval this cycle
o_mcause  out  32  captured cause
o_mepc  out  32  captured pc, bits[1:0] forced 0
o_mtval  out  32  captured val or 0
o_mstatus_trap  out  1  MPIE<=MIE, MIE<=0, MPP<=M
o_mstatus_mret  out  1  MIE<=MPIE, MPIE<=1
o_redirect_valid  out  1  fetch redirect request
o_redirect_pc  out  32  redirect target
i_redirect_ready  in  1  fetch accepts redirect
o_trap_handled  out  1  one-cycle ack to priority unit
o_busy  out  1  state != IDLE

Behaviour:
- Async reset: state IDLE, all outputs and capture registers 0, effective immediately, including mid-sequence.
- States: IDLE, FLUSH, SAVE, REDIRECT, ACK. Flag r_is_mret selects the trap or mret path.
- IDLE:
  - i_trap_pending=1: capture cause, pc & ~3, val (or 0 if !MTVAL_EN); r_is_mret=0; go to FLUSH.
  - Else i_mret=1: r_is_mret=1; go to FLUSH.
  - Trap wins over simultaneous mret.
- FLUSH: o_flush=1. Stay while !i_pipe_empty. When i_pipe_empty=1, go to SAVE next cycle. Minimum one FLUSH cycle even if already empty.
- SAVE (exactly 1 cycle):
  - Trap path: o_csr_we=1 and o_mstatus_trap=1.
  - Mret path: o_mstatus_mret=1, o_csr_we=0.
  - Compute the redirect target and register it. Go to REDIRECT.
- Target (trap):
  - base = {i_mtvec[31:2],2'b00}.
  - If VECTORED_EN and i_mtvec[1:0]==2'b01 and cause[31]: base + (cause[30:0]<<2), 32-bit wrap.
  - Otherwise base. Modes 2'b10/2'b11 are treated as direct.
- Target (mret): {i_mepc[31:2],2'b00}, sampled in SAVE.
- REDIRECT: o_redirect_valid=1 and o_redirect_pc held stable until i_redirect_ready. On acceptance, trap path goes to ACK and mret path goes to IDLE.
- ACK (1 cycle): o_trap_handled=1, then IDLE. i_trap_pending is ignored in ACK. The first cycle back in IDLE may accept a new trap.
- Inputs i_trap_pending and i_mret are ignored outside IDLE. Exceptions raised by flushed instructions are discarded by the ACK clear.
- A trap arriving during an mret sequence remains pending in the priority unit and is taken from IDLE afterwards.
- Minimum trap latency, pending to handled: 5 cycles (IDLE capture, FLUSH, SAVE, REDIRECT with ready=1, ACK).
- o_mcause/o_mepc/o_mtval hold their captured values until the next capture.

Decomposition:
- trap_pkg:
  - state enum.
  - MTVEC_MODE_DIRECT=2'b00 and MTVEC_MODE_VECTORED=2'b01.
  - mcause code constants: illegal=2, ecall_m=11, mtimer_irq=32'h8000_0007, mext_irq=32'h8000_000B.
- One combinational sub-module trap_vector_calc: mtvec, cause and VECTORED_EN in, target pc out.

Test Plan:
1. Cause 2, pc 0x0000_0106, val 0xDEAD_BEEF, mtvec 0x0000_0200, pipe_empty after 3 cycles -> o_flush 3 cycles; SAVE with mcause 2, mepc 0x104, mtval 0xDEADBEEF, mstatus_trap=1; redirect 0x200; single handled pulse.
2. Cause 0x8000_0007, mtvec 0x0000_1001, VECTORED_EN=1 -> redirect 0x0000_101C. With VECTORED_EN=0 -> 0x0000_1000. With mtvec 0x0000_1003 -> 0x0000_1000.
3. i_redirect_ready low 4 cycles -> valid and pc stable all 4 cycles; handled asserted only in the cycle after acceptance.
4. mret with mepc 0x0000_0302 -> mstatus_mret=1, csr_we=0, redirect 0x300, no handled pulse. Simultaneous mret+trap -> trap path taken.
5. Async reset asserted mid-REDIRECT -> all outputs 0 without a clock edge; IDLE after release; a new trap is serviced normally.
6. Pending held high through ACK, then deasserted -> no second trap entry; back-to-back new trap on the first IDLE cycle is captured.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/mret sequencer.
package trap_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_SAVE     = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_ACK      = 3'd4
    } trap_state_e;

    // mtvec mode field encodings
    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // mcause codes used around the trap path
    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_MTIMER_IRQ = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEXT_IRQ   = 32'h8000_000B;

    // Clear the two low address bits (word alignment for pcs and vector bases)
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/trap_vector_calc.sv
// Trap target computation from mtvec and mcause (direct or vectored).
module trap_vector_calc
    import trap_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic [31:0] mtvec,
    input  logic [31:0] cause,
    output logic [31:0] target
);

    logic [31:0] base_s;
    logic [31:0] offset_s;
    logic        vectored_s;

    // Interrupts in vectored mode land at base + 4*code; everything else at base
    always_comb begin
        base_s     = word_align(mtvec);
        offset_s   = cause << 2;
        vectored_s = VECTORED_EN && (mtvec[1:0] == MTVEC_MODE_VECTORED) && cause[31];
        if (vectored_s) begin
            target = base_s + offset_s;
        end else begin
            target = base_s;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap/mret sequencer: drains the pipe, writes trap CSRs, redirects fetch
// and acknowledges the priority unit. All outputs are registered.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1,
    parameter bit MTVAL_EN    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trap_pending,
    input  logic [31:0] i_trap_cause,
    input  logic [31:0] i_trap_pc,
    input  logic [31:0] i_trap_val,
    input  logic        i_mret,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    input  logic        i_pipe_empty,
    output logic        o_flush,
    output logic        o_csr_we,
    output logic [31:0] o_mcause,
    output logic [31:0] o_mepc,
    output logic [31:0] o_mtval,
    output logic        o_mstatus_trap,
    output logic        o_mstatus_mret,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    input  logic        i_redirect_ready,
    output logic        o_trap_handled,
    output logic        o_busy
);

    trap_state_e state_r;
    trap_state_e state_s;
    logic        is_mret_r;
    logic        is_mret_s;
    logic        capture_s;
    logic [31:0] trap_val_s;
    logic [31:0] vec_target_s;
    logic [31:0] target_s;

    trap_vector_calc #(
        .VECTORED_EN (VECTORED_EN)
    ) u_vector_calc (
        .mtvec  (i_mtvec),
        .cause  (o_mcause),
        .target (vec_target_s)
    );

    // Redirect target: mtvec-derived for traps, aligned mepc for mret
    always_comb begin
        trap_val_s = MTVAL_EN ? i_trap_val : 32'd0;
        if (is_mret_r) begin
            target_s = word_align(i_mepc);
        end else begin
            target_s = vec_target_s;
        end
    end

    // Next-state logic; trap/mret requests are only looked at in IDLE
    always_comb begin
        state_s   = state_r;
        is_mret_s = is_mret_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_trap_pending) begin
                    capture_s = 1'b1;
                    is_mret_s = 1'b0;
                    state_s   = ST_FLUSH;
                end else if (i_mret) begin
                    is_mret_s = 1'b1;
                    state_s   = ST_FLUSH;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (i_pipe_empty) begin
                    state_s = ST_SAVE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_SAVE: begin
                state_s = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (i_redirect_ready) begin
                    if (is_mret_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ACK;
                    end
                end else begin
                    state_s = ST_REDIRECT;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, path flag and registered outputs decoded from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r          <= ST_IDLE;
            is_mret_r        <= 1'b0;
            o_flush          <= 1'b0;
            o_csr_we         <= 1'b0;
            o_mstatus_trap   <= 1'b0;
            o_mstatus_mret   <= 1'b0;
            o_redirect_valid <= 1'b0;
            o_trap_handled   <= 1'b0;
            o_busy           <= 1'b0;
        end else begin
            state_r          <= state_s;
            is_mret_r        <= is_mret_s;
            o_flush          <= (state_s == ST_FLUSH);
            o_csr_we         <= (state_s == ST_SAVE) && !is_mret_s;
            o_mstatus_trap   <= (state_s == ST_SAVE) && !is_mret_s;
            o_mstatus_mret   <= (state_s == ST_SAVE) && is_mret_s;
            o_redirect_valid <= (state_s == ST_REDIRECT);
            o_trap_handled   <= (state_s == ST_ACK);
            o_busy           <= (state_s != ST_IDLE);
        end
    end

    // Trap CSR capture; values hold until the next trap is accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mcause <= 32'd0;
            o_mepc   <= 32'd0;
            o_mtval  <= 32'd0;
        end else if (capture_s) begin
            o_mcause <= i_trap_cause;
            o_mepc   <= word_align(i_trap_pc);
            o_mtval  <= trap_val_s;
        end else begin
            o_mcause <= o_mcause;
            o_mepc   <= o_mepc;
            o_mtval  <= o_mtval;
        end
    end

    // Redirect target is sampled in SAVE and held stable through REDIRECT
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_redirect_pc <= 32'd0;
        end else if (state_r == ST_SAVE) begin
            o_redirect_pc <= target_s;
        end else begin
            o_redirect_pc <= o_redirect_pc;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a directed table, randomized
// transactions against a transaction-level model, and hand-written
// reset / back-to-back sequences. Two instances: vectored+mtval, and
// direct-only with mtval disabled.
module tb_trap_sequencer;
    import trap_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_trap_pending;
    logic [31:0] i_trap_cause;
    logic [31:0] i_trap_pc;
    logic [31:0] i_trap_val;
    logic        i_mret;
    logic [31:0] i_mtvec;
    logic [31:0] i_mepc;
    logic        i_pipe_empty;
    logic        i_redirect_ready;

    logic        d0_flush, d0_csr_we, d0_mst_trap, d0_mst_mret, d0_rvalid, d0_handled, d0_busy;
    logic [31:0] d0_mcause, d0_mepc, d0_mtval, d0_rpc;
    logic        d1_flush, d1_csr_we, d1_mst_trap, d1_mst_mret, d1_rvalid, d1_handled, d1_busy;
    logic [31:0] d1_mcause, d1_mepc, d1_mtval, d1_rpc;

    trap_sequencer #(.VECTORED_EN(1'b1), .MTVAL_EN(1'b1)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_trap_pending(i_trap_pending),
        .i_trap_cause(i_trap_cause), .i_trap_pc(i_trap_pc), .i_trap_val(i_trap_val),
        .i_mret(i_mret), .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_pipe_empty(i_pipe_empty),
        .o_flush(d0_flush), .o_csr_we(d0_csr_we), .o_mcause(d0_mcause), .o_mepc(d0_mepc),
        .o_mtval(d0_mtval), .o_mstatus_trap(d0_mst_trap), .o_mstatus_mret(d0_mst_mret),
        .o_redirect_valid(d0_rvalid), .o_redirect_pc(d0_rpc),
        .i_redirect_ready(i_redirect_ready), .o_trap_handled(d0_handled), .o_busy(d0_busy)
    );

    trap_sequencer #(.VECTORED_EN(1'b0), .MTVAL_EN(1'b0)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_trap_pending(i_trap_pending),
        .i_trap_cause(i_trap_cause), .i_trap_pc(i_trap_pc), .i_trap_val(i_trap_val),
        .i_mret(i_mret), .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_pipe_empty(i_pipe_empty),
        .o_flush(d1_flush), .o_csr_we(d1_csr_we), .o_mcause(d1_mcause), .o_mepc(d1_mepc),
        .o_mtval(d1_mtval), .o_mstatus_trap(d1_mst_trap), .o_mstatus_mret(d1_mst_mret),
        .o_redirect_valid(d1_rvalid), .o_redirect_pc(d1_rpc),
        .i_redirect_ready(i_redirect_ready), .o_trap_handled(d1_handled), .o_busy(d1_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected control vector {flush, csr_we, mst_trap, mst_mret, rvalid, handled, busy}
    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_FLUSH  = 7'b1000001;
    localparam logic [6:0] C_SAVE_T = 7'b0110001;
    localparam logic [6:0] C_SAVE_M = 7'b0001001;
    localparam logic [6:0] C_REDIR  = 7'b0000101;
    localparam logic [6:0] C_ACK    = 7'b0000011;

    typedef struct {
        logic [1:0]  kind;      // 0 trap, 1 mret, 2 trap+mret together
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] val;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        int          flush_n;   // FLUSH cycles (>=1)
        int          wait_n;    // REDIRECT cycles with ready low
        logic [31:0] exp_mepc;
        logic [31:0] exp_tgt0;  // vectored instance
        logic [31:0] exp_tgt1;  // direct-only instance
    } txn_t;

    int n_checks = 0;
    int n_errors = 0;

    // Expected architectural state held by the bench
    logic [31:0] em_cause = 32'd0, em_epc = 32'd0, em_val0 = 32'd0, em_val1 = 32'd0;
    logic [31:0] erpc0 = 32'd0, erpc1 = 32'd0;

    txn_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input logic [6:0] ectl);
        chk("ctrl", {25'd0, d0_flush, d0_csr_we, d0_mst_trap, d0_mst_mret, d0_rvalid, d0_handled, d0_busy}, {25'd0, ectl});
        chk("ctrl_direct", {25'd0, d1_flush, d1_csr_we, d1_mst_trap, d1_mst_mret, d1_rvalid, d1_handled, d1_busy}, {25'd0, ectl});
        chk("mcause", d0_mcause, em_cause);
        chk("mepc", d0_mepc, em_epc);
        chk("mtval", d0_mtval, em_val0);
        chk("redirect_pc", d0_rpc, erpc0);
        chk("mcause_direct", d1_mcause, em_cause);
        chk("mepc_direct", d1_mepc, em_epc);
        chk("mtval_direct", d1_mtval, em_val1);
        chk("redirect_pc_direct", d1_rpc, erpc1);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference target: architectural rule written with plain arithmetic
    function automatic logic [31:0] model_target(input logic [31:0] mtvec, input logic [31:0] cause, input bit vec_en);
        logic [31:0] base;
        base = mtvec - (mtvec % 32'd4);
        if (vec_en && (mtvec % 32'd4 == 32'd1) && (cause >= 32'h8000_0000)) begin
            return base + (cause - 32'h8000_0000) * 32'd4;
        end
        return base;
    endfunction

    // Random values on every input the sequencer should ignore in this cycle
    task automatic noise_inputs(input bit noise);
        if (noise) begin
            i_trap_pending   = ($urandom_range(1, 0) == 1);
            i_mret           = ($urandom_range(1, 0) == 1);
            i_trap_cause     = $urandom;
            i_trap_pc        = $urandom;
            i_trap_val       = $urandom;
            i_mtvec          = $urandom;
            i_mepc           = $urandom;
            i_pipe_empty     = ($urandom_range(1, 0) == 1);
            i_redirect_ready = ($urandom_range(1, 0) == 1);
        end
    endtask

    // One complete trap or mret sequence, started from IDLE, checked every cycle
    task automatic run_txn(input txn_t t, input bit noise);
        bit is_trap;
        is_trap        = (t.kind != 2'd1);
        noise_inputs(noise);
        i_trap_pending = is_trap;
        i_mret         = (t.kind != 2'd0);
        i_trap_cause   = t.cause;
        i_trap_pc      = t.pc;
        i_trap_val     = t.val;
        if (!noise) begin
            i_mtvec          = t.mtvec;
            i_mepc           = t.mepc;
            i_pipe_empty     = 1'b0;
            i_redirect_ready = 1'b0;
        end
        step();
        if (is_trap) begin
            em_cause = t.cause;
            em_epc   = t.exp_mepc;
            em_val0  = t.val;
            em_val1  = 32'd0;
        end
        for (int f = 1; f <= t.flush_n; f++) begin
            check_all(C_FLUSH);
            noise_inputs(noise);
            i_pipe_empty = (f == t.flush_n);
            step();
        end
        check_all(is_trap ? C_SAVE_T : C_SAVE_M);
        noise_inputs(noise);
        i_mtvec = t.mtvec;
        i_mepc  = t.mepc;
        step();
        erpc0 = t.exp_tgt0;
        erpc1 = t.exp_tgt1;
        for (int w = 0; w <= t.wait_n; w++) begin
            check_all(C_REDIR);
            noise_inputs(noise);
            i_redirect_ready = (w == t.wait_n);
            step();
        end
        if (is_trap) begin
            check_all(C_ACK);
            noise_inputs(noise);
            step();
        end
        check_all(C_IDLE);
    endtask

    task automatic idle_cycles(input int n);
        i_trap_pending = 1'b0;
        i_mret         = 1'b0;
        for (int k = 0; k < n; k++) begin
            step();
            check_all(C_IDLE);
        end
    endtask

    initial begin
        txn_t r;

        tbl[0] = '{2'd0, CAUSE_ILLEGAL, 32'h0000_0106, 32'hDEAD_BEEF, 32'h0000_0200, 32'h0, 3, 0, 32'h0000_0104, 32'h0000_0200, 32'h0000_0200};
        tbl[1] = '{2'd0, CAUSE_MTIMER_IRQ, 32'h0000_0400, 32'h0, 32'h0000_1001, 32'h0, 1, 0, 32'h0000_0400, 32'h0000_101C, 32'h0000_1000};
        tbl[2] = '{2'd0, CAUSE_MTIMER_IRQ, 32'h0000_0400, 32'h1, 32'h0000_1003, 32'h0, 1, 0, 32'h0000_0400, 32'h0000_1000, 32'h0000_1000};
        tbl[3] = '{2'd0, CAUSE_MEXT_IRQ, 32'h0000_0808, 32'h1234_5678, 32'h0000_1001, 32'h0, 2, 4, 32'h0000_0808, 32'h0000_102C, 32'h0000_1000};
        tbl[4] = '{2'd1, 32'h0, 32'h0, 32'h0, 32'h0000_0200, 32'h0000_0302, 1, 0, 32'h0, 32'h0000_0300, 32'h0000_0300};
        tbl[5] = '{2'd2, CAUSE_ECALL_M, 32'h0000_2003, 32'h0000_00AA, 32'h0000_0100, 32'h0000_0302, 1, 1, 32'h0000_2000, 32'h0000_0100, 32'h0000_0100};
        tbl[6] = '{2'd0, CAUSE_MTIMER_IRQ, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0, 1, 0, 32'hFFFF_FFFC, 32'h0000_000C, 32'hFFFF_FFF0};
        tbl[7] = '{2'd0, CAUSE_MTIMER_IRQ, 32'h0000_0010, 32'h0, 32'h0000_1002, 32'h0, 1, 0, 32'h0000_0010, 32'h0000_1000, 32'h0000_1000};
        tbl[8] = '{2'd1, 32'h0, 32'h0, 32'h0, 32'h0000_0200, 32'hFFFF_FFFF, 2, 2, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        tbl[9] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0044, 32'h0000_0055, 32'h0000_0001, 32'h0, 1, 0, 32'h0000_0044, 32'hFFFF_FFFC, 32'h0000_0000};

        i_rst = 1'b1; i_trap_pending = 1'b0; i_mret = 1'b0;
        i_trap_cause = 32'd0; i_trap_pc = 32'd0; i_trap_val = 32'd0;
        i_mtvec = 32'd0; i_mepc = 32'd0; i_pipe_empty = 1'b0; i_redirect_ready = 1'b0;
        #3;
        check_all(C_IDLE);
        step();
        step();
        i_rst = 1'b0;
        step();
        check_all(C_IDLE);

        // Directed table, back to back (each trap starts on the first IDLE cycle)
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], 1'b0);
        end

        // Pending held through ACK then dropped: no second entry
        run_txn(tbl[0], 1'b0);
        idle_cycles(3);

        // Async reset in the middle of REDIRECT
        i_trap_pending = 1'b1; i_mret = 1'b0; i_trap_cause = CAUSE_ECALL_M;
        i_trap_pc = 32'h0000_0500; i_trap_val = 32'h0000_0055; i_mtvec = 32'h0000_0200;
        i_pipe_empty = 1'b1; i_redirect_ready = 1'b0;
        step();
        em_cause = CAUSE_ECALL_M; em_epc = 32'h0000_0500; em_val0 = 32'h0000_0055; em_val1 = 32'd0;
        check_all(C_FLUSH);
        step();
        check_all(C_SAVE_T);
        step();
        erpc0 = 32'h0000_0200; erpc1 = 32'h0000_0200;
        check_all(C_REDIR);
        #1 i_rst = 1'b1;
        #1;
        em_cause = 32'd0; em_epc = 32'd0; em_val0 = 32'd0; em_val1 = 32'd0;
        erpc0 = 32'd0; erpc1 = 32'd0;
        check_all(C_IDLE);
        i_trap_pending = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        idle_cycles(1);
        run_txn(tbl[3], 1'b0);

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            r.kind = 2'($urandom_range(2, 0));
            case ($urandom_range(2, 0))
                0:       r.cause = 32'($urandom_range(15, 0));
                1:       r.cause = 32'h8000_0000 | 32'($urandom_range(15, 0));
                default: r.cause = $urandom;
            endcase
            r.pc      = $urandom;
            r.val     = $urandom;
            r.mtvec   = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(3, 0));
            r.mepc    = $urandom;
            r.flush_n = $urandom_range(4, 1);
            r.wait_n  = $urandom_range(3, 0);
            r.exp_mepc = r.pc - (r.pc % 32'd4);
            if (r.kind == 2'd1) begin
                r.exp_tgt0 = r.mepc - (r.mepc % 32'd4);
                r.exp_tgt1 = r.exp_tgt0;
            end else begin
                r.exp_tgt0 = model_target(r.mtvec, r.cause, 1'b1);
                r.exp_tgt1 = model_target(r.mtvec, r.cause, 1'b0);
            end
            run_txn(r, 1'b1);
        end
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
